// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use stalls, taken-branch flushes of IF/ID, and a front-end hold
// while the multi-cycle MDU is busy. The MDU hold is bounded by a watchdog.
// Also keeps a stall-cycle performance counter and a sticky watchdog error.
module pipeline_hazard_controller #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32,
    parameter int MDU_MAX = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mdu_start,
    input  logic              mdu_done,
    output logic              pc_pause,
    output logic              if_id_pause,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              mdu_busy,
    output logic              mdu_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Watchdog counts 0 .. MDU_MAX-1 while waiting on the MDU.
    localparam int WD_W = $clog2(MDU_MAX);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wdog;
    logic [WD_W-1:0] wdog_nxt;
    logic            load_use;
    logic            tmo_set;

    // A load in EX writing a register the ID instruction reads; r0 never hazards.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) ||
                    (id_uses_rt && (id_rt == ex_rd)));
    end

    // Next-state and stall/flush outputs. Load-use takes priority in RUN so the
    // stalled instruction re-presents its branch/MDU request next cycle.
    always_comb begin
        state_nxt    = state;
        wdog_nxt     = wdog;
        tmo_set      = 1'b0;
        pc_pause     = 1'b0;
        if_id_pause  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mdu_busy     = 1'b0;
        case (state)
            RUN: begin
                if (load_use) begin
                    pc_pause     = 1'b1;
                    if_id_pause  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                    end
                    if (mdu_start) begin
                        state_nxt = MDU_WAIT;
                        wdog_nxt  = '0;
                    end
                end
            end
            MDU_WAIT: begin
                // Front end stays held through the done cycle itself.
                pc_pause     = 1'b1;
                if_id_pause  = 1'b1;
                id_ex_bubble = 1'b1;
                mdu_busy     = 1'b1;
                if (mdu_done) begin
                    state_nxt = RUN;
                end else if (wdog == WD_LAST) begin
                    tmo_set   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // FSM state and watchdog registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            wdog  <= wdog_nxt;
        end
    end

    // Sticky watchdog error; cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdu_timeout <= 1'b0;
        end else if (tmo_set) begin
            mdu_timeout <= 1'b1;
        end
    end

    // Stall performance counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (pc_pause) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
